// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, type-field position and the
// head/tail classifiers used by the FIFO, route-compute and arbiter stages.
package noc_pkg;

   // Two-bit flit type carried in the top bits of every flit
   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_TAIL   = 2'b01,
      FLIT_HEAD   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   // Output-port arbiter FSM states
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam int FLIT_WIDTH    = 64;
   localparam int FLIT_TYPE_MSB = FLIT_WIDTH - 1;
   localparam int FLIT_TYPE_LSB = FLIT_WIDTH - 2;

   // A flit that opens a packet (and may therefore win arbitration)
   function automatic logic is_head(input flit_type_e t);
      return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
   endfunction

   // A flit that closes a packet
   function automatic logic is_tail(input flit_type_e t);
      return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/noc_out_port_arbiter_if.sv
// Flit bus between the input FIFOs, the output-port arbiter and the link.
interface noc_out_port_arbiter_if #(
   parameter int WIDTH  = 64,
   parameter int NUM_IN = 5
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;

   // FIFO/link side
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   // Arbiter side
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/noc_out_port_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after
// ptr (wrapping) wins. No state lives here.
module rr_arbiter #(
   parameter int N = 5,
   localparam int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] gnt_id,
   output logic             any
);
   int   idx_s;
   logic hit_s;

   // Scan requesters starting at ptr and keep the first one found
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx_s  = 0;
      hit_s  = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx_s      = (int'(ptr) + k) % N;
         hit_s      = !any && req[idx_s];
         gnt[idx_s] = gnt[idx_s] | hit_s;
         gnt_id     = hit_s ? PTR_W'(idx_s) : gnt_id;
         any        = any | hit_s;
      end
   end
endmodule

// File: rtl/noc_out_port_arbiter.sv
// Router output-port stage: wormhole round-robin arbitration of NUM_IN input
// FIFOs onto one registered ready/valid link. A winning HEAD keeps the port
// until its TAIL has been sent.
module noc_out_port_arbiter
   import noc_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int NUM_IN = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   noc_out_port_arbiter_if.slave bus,
   output logic                  lock_busy,
   output logic                  proto_err
);
   localparam int PTR_W = $clog2(NUM_IN);

   arb_state_e        state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              proto_err_q, proto_err_d;

   flit_type_e        type_s [NUM_IN];
   logic [NUM_IN-1:0] head_req_s;
   logic [NUM_IN-1:0] bad_s;
   logic [NUM_IN-1:0] gnt_s;
   logic [PTR_W-1:0]  gnt_id_s;
   logic              any_s;
   logic [PTR_W-1:0]  sel_id_s;
   logic [WIDTH-1:0]  sel_flit_s;
   flit_type_e        sel_type_s;
   logic              can_load_s;
   logic              fire_s;
   logic [NUM_IN-1:0] in_ready_s;

   function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] id);
      if (id == PTR_W'(NUM_IN - 1)) begin
         return '0;
      end else begin
         return id + PTR_W'(1);
      end
   endfunction

   // Classify the flit waiting at each input: packet openers compete, others are only legal under a lock
   always_comb begin
      head_req_s = '0;
      bad_s      = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         type_s[i]     = flit_type_e'(bus.in_data[i*WIDTH + WIDTH - 2 +: 2]);
         head_req_s[i] = bus.in_valid[i] && is_head(type_s[i]);
         bad_s[i]      = bus.in_valid[i] && !is_head(type_s[i]);
      end
   end

   rr_arbiter #(.N(NUM_IN)) u_rr_arbiter (
      .req    (head_req_s),
      .ptr    (rr_ptr_q),
      .gnt    (gnt_s),
      .gnt_id (gnt_id_s),
      .any    (any_s)
   );

   // Pick the flit that would be forwarded: the lock owner, else the arbitration winner
   always_comb begin
      can_load_s = !out_valid_q || bus.out_ready;
      sel_id_s   = (state_q == LOCKED) ? owner_q : gnt_id_s;
      sel_flit_s = bus.in_data[sel_id_s*WIDTH +: WIDTH];
      sel_type_s = flit_type_e'(sel_flit_s[WIDTH-1 -: 2]);
   end

   // Wormhole FSM: grant, lock/unlock, round-robin pointer and protocol-error detection
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      proto_err_d = proto_err_q;
      in_ready_s  = '0;
      fire_s      = 1'b0;
      case (state_q)
         IDLE: begin
            proto_err_d = proto_err_q | (|bad_s);
            if (any_s && can_load_s) begin
               in_ready_s = gnt_s;
               fire_s     = 1'b1;
               if (is_tail(sel_type_s)) begin
                  rr_ptr_d = next_port(gnt_id_s);
               end else begin
                  owner_d = gnt_id_s;
                  state_d = LOCKED;
               end
            end else begin
               in_ready_s = '0;
            end
         end
         LOCKED: begin
            in_ready_s[owner_q] = can_load_s;
            fire_s = can_load_s && bus.in_valid[owner_q];
            // Only a genuine TAIL ends the packet; stray HEAD/SINGLE at the owner just pass through
            if (fire_s && (sel_type_s == FLIT_TAIL)) begin
               rr_ptr_d = next_port(owner_q);
               state_d  = IDLE;
            end else begin
               state_d = LOCKED;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register: load on transfer, drop valid once accepted, otherwise hold
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (fire_s) begin
         out_data_d  = sel_flit_s;
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State and output flops with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Pops are suppressed while reset is held
   assign bus.in_ready  = in_ready_s & {NUM_IN{~rst}};
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign lock_busy     = (state_q == LOCKED);
   assign proto_err     = proto_err_q;
endmodule
